lift_request_panel: RTL and testbench
=====================================

LIFT_REQUEST_PANEL -- requirements
Module: lift_request_panel

Interface
REQ-001 The block SHALL have parameter FLOORS, default 16: number of floors and width of the request vector.
REQ-002 The block SHALL have parameter DEB_TICKS, default 3: consecutive identical tick samples required to accept a button level.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 tick  in  1  one-clk sample strobe, e.g. 200 ms enable.
REQ-006 sw  in  FLOORS  raw floor-call buttons, 1 = pressed, asynchronous to clk.
REQ-007 lift_num  in  4  current car floor, synchronous to clk.
REQ-008 lift_open  in  1  door open at lift_num, synchronous to clk.
REQ-009 req  out  FLOORS  latched pending calls, bit i = floor i.
REQ-010 req_here  out  1  req[lift_num] set.
REQ-011 req_above  out  1  any req bit with index > lift_num.
REQ-012 req_below  out  1  any req bit with index < lift_num.
REQ-013 req_count  out  5  number of set req bits, 0..16.

Function
REQ-014 Each sw bit SHALL pass through a 2-FF synchronizer before any other use.
REQ-015 Debounced level for floor i SHALL change only after DEB_TICKS consecutive tick samples differ from the current debounced level; the counter SHALL clear on any tick sample that equals the current level.
REQ-016 A 0->1 transition of debounced floor i SHALL set req[i] on the next clk edge; a held button SHALL NOT re-set a cleared bit.
REQ-017 A 1->0 debounced transition SHALL have no effect on req.
REQ-018 While lift_open=1, req[lift_num] SHALL be cleared on every clk edge.
REQ-019 Set and clear of the same floor on the same edge: clear SHALL win.
REQ-020 lift_num >= FLOORS SHALL clear nothing and SHALL drive req_here=0 and req_above=0; req_below is then the OR of all req bits.
REQ-021 Sets and clears of different floors on the same edge SHALL both take effect.
REQ-022 req SHALL be a register; req_here, req_above, req_below and req_count SHALL be registered from the next-state req and the current lift_num, so all outputs are consistent on the same cycle.
REQ-023 Latency SHALL be: sw edge to req set = 2 sync + DEB_TICKS ticks + 1 clk; lift_open to clear = 1 clk.
REQ-024 req_count SHALL be a saturation-free popcount, maximum 16, in 5 bits.
REQ-025 With tick=0, debounce state SHALL hold; clears SHALL still act.

Reset
REQ-026 rst_n=0 SHALL asynchronously force req, req_here, req_above, req_below, req_count, the synchronizers, the debounced levels and the debounce counters to 0.
REQ-027 A button held through reset deassertion SHALL register as one new call after debounce.
REQ-028 Reset asserted mid-debounce SHALL discard the partial count.

Structure
REQ-029 Package lift_pkg SHALL hold FLOORS, FLOOR_W=4 and the DEB_TICKS default; lift_main SHALL share it.
REQ-030 The per-bit synchronizer, debounce counter and edge detector SHALL be one sub-module, lift_debounce, instantiated FLOORS times.
REQ-031 The request register, clear logic and summary outputs SHALL live in lift_request_panel.

Verification
REQ-032 Press sw[5] steady for 4 ticks -> req=0x0020 and req_count=1 after 2+3 ticks +1 clk; req_above=1 with lift_num=3.
REQ-033 Toggle sw[7] every tick for 10 ticks -> req[7] stays 0.
REQ-034 With req=0x0028, lift_num=3 and lift_open=1 for 1 clk -> req=0x0020 next clk, req_here=0, req_count=1.
REQ-035 Debounced rise of floor 3 on the edge where lift_num=3 and lift_open=1 -> req[3]=0; hold the button -> it stays 0 after the door closes.
REQ-036 Set req=0xFFFF, then pulse rst_n low mid-cycle -> all outputs 0 immediately, without waiting for a clk edge.
REQ-037 Set req=0x8001 with lift_num=0 -> req_here=1, req_above=1, req_below=0, req_count=2; then lift_num=15 -> req_here=1, req_above=0, req_below=1.

Source files
------------

// File: rtl/lift_pkg.sv
// Shared constants and types for the lift request panel and its per-floor debounce.
package lift_pkg;
    localparam int FLOORS    = 16;
    localparam int FLOOR_W   = 4;
    localparam int DEB_TICKS = 3;
    localparam int COUNT_W   = FLOOR_W + 1;

    typedef struct packed {
        logic               here;
        logic               above;
        logic               below;
        logic [COUNT_W-1:0] count;
    } summary_t;
endpackage

// File: rtl/lift_debounce.sv
// One floor button: 2-FF synchronizer, tick-sampled debounce counter, rising-edge pulse.
module lift_debounce
    import lift_pkg::*;
#(
    parameter int DEB_TICKS = lift_pkg::DEB_TICKS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic sw,
    output logic rise
);
    localparam int CW = $clog2(DEB_TICKS + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          level;
    logic          level_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync    <= '0;
            cnt     <= '0;
            level   <= 1'b0;
            level_d <= 1'b0;
        end else begin
            sync    <= {sync[0], sw};
            level_d <= level;
            // Any sample agreeing with the accepted level restarts the run.
            if (tick) begin
                if (sync[1] == level) begin
                    cnt <= '0;
                end else if (cnt == CW'(DEB_TICKS - 1)) begin
                    level <= sync[1];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

    assign rise = level & ~level_d;
endmodule

// File: rtl/lift_request_panel.sv
// Latched floor-call register with door-open clearing and registered summary flags.
module lift_request_panel
    import lift_pkg::*;
#(
    parameter int FLOORS    = lift_pkg::FLOORS,
    parameter int DEB_TICKS = lift_pkg::DEB_TICKS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic [FLOORS-1:0]  sw,
    input  logic [FLOOR_W-1:0] lift_num,
    input  logic               lift_open,
    output logic [FLOORS-1:0]  req,
    output logic               req_here,
    output logic               req_above,
    output logic               req_below,
    output logic [COUNT_W-1:0] req_count
);
    logic [FLOORS-1:0] rise;
    logic [FLOORS-1:0] clr;
    logic [FLOORS-1:0] req_nxt;
    summary_t          sum_nxt;
    summary_t          sum_q;

    for (genvar g = 0; g < FLOORS; g++) begin : g_floor
        lift_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb (
            .clk  (clk),
            .rst_n(rst_n),
            .tick (tick),
            .sw   (sw[g]),
            .rise (rise[g])
        );
    end

    // Out-of-range lift_num matches no floor, so nothing is cleared.
    always_comb begin
        clr = '0;
        for (int i = 0; i < FLOORS; i++) begin
            if (lift_open && (int'(lift_num) == i)) clr[i] = 1'b1;
        end
    end

    assign req_nxt = (req | rise) & ~clr;

    always_comb begin
        sum_nxt = '0;
        for (int i = 0; i < FLOORS; i++) begin
            if (req_nxt[i]) begin
                sum_nxt.count = sum_nxt.count + COUNT_W'(1);
                if (i == int'(lift_num))     sum_nxt.here  = 1'b1;
                else if (i > int'(lift_num)) sum_nxt.above = 1'b1;
                else                         sum_nxt.below = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req   <= '0;
            sum_q <= '0;
        end else begin
            req   <= req_nxt;
            sum_q <= sum_nxt;
        end
    end

    assign req_here  = sum_q.here;
    assign req_above = sum_q.above;
    assign req_below = sum_q.below;
    assign req_count = sum_q.count;
endmodule

// File: tb/tb_lift_request_panel.sv
// Directed stimulus pushes expected snapshots; a monitor pops and compares them.
module tb_lift_request_panel;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic [15:0] sw = '0;
    logic [3:0]  lift_num = '0;
    logic        lift_open = 1'b0;
    logic [15:0] req;
    logic        req_here, req_above, req_below;
    logic [4:0]  req_count;

    lift_request_panel dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .sw       (sw),
        .lift_num (lift_num),
        .lift_open(lift_open),
        .req      (req),
        .req_here (req_here),
        .req_above(req_above),
        .req_below(req_below),
        .req_count(req_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] req;
        logic        here;
        logic        above;
        logic        below;
        logic [4:0]  count;
    } exp_t;

    exp_t sb[$];
    exp_t e_m;
    event chk_ev;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic cmp(input string name, input string fld, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s.%s: got %h, expected %h", name, fld, act, exp);
        end
    endtask

    always @(chk_ev) begin
        while (sb.size() > 0) begin
            e_m = sb.pop_front();
            cmp(e_m.name, "req",   req,              e_m.req);
            cmp(e_m.name, "here",  16'(req_here),    16'(e_m.here));
            cmp(e_m.name, "above", 16'(req_above),   16'(e_m.above));
            cmp(e_m.name, "below", 16'(req_below),   16'(e_m.below));
            cmp(e_m.name, "count", 16'(req_count),   16'(e_m.count));
        end
    end

    task automatic expect_out(input string name, input logic [15:0] r, input logic h,
                              input logic a, input logic b, input logic [4:0] c);
        exp_t e;
        e.name = name; e.req = r; e.here = h; e.above = a; e.below = b; e.count = c;
        sb.push_back(e);
        ->chk_ev;
    endtask

    // Ends 2 time units after a rising edge, clear of both clock edges.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            tick = 1'b1; cyc(1);
            tick = 1'b0; cyc(1);
        end
    endtask

    initial begin
        cyc(2);
        expect_out("reset", 16'h0000, 0, 0, 0, 5'd0);
        rst_n = 1'b1; lift_num = 4'd3;
        cyc(1);

        // Steady press of floor 5: 2 sync clocks, 3 ticks, 1 clk
        sw = 16'h0020; cyc(2);
        tick_n(2);
        expect_out("sw5_partial", 16'h0000, 0, 0, 0, 5'd0);
        tick_n(1);
        expect_out("sw5_set", 16'h0020, 0, 1, 0, 5'd1);
        tick_n(1);
        expect_out("sw5_hold", 16'h0020, 0, 1, 0, 5'd1);

        // Chattering floor 7 never reaches three agreeing samples
        repeat (10) begin
            sw[7] = ~sw[7]; cyc(2); tick_n(1);
        end
        expect_out("toggle7", 16'h0020, 0, 1, 0, 5'd1);

        // Floor 3 call, then door open at 3 for one clk
        sw[3] = 1'b1; cyc(2); tick_n(3);
        expect_out("sw3_set", 16'h0028, 1, 1, 0, 5'd2);
        lift_open = 1'b1; cyc(1); lift_open = 1'b0;
        expect_out("open3", 16'h0020, 0, 1, 0, 5'd1);
        cyc(1);
        expect_out("closed3", 16'h0020, 0, 1, 0, 5'd1);

        // Release has no effect; re-press rising while door open is swallowed
        sw[3] = 1'b0; cyc(2); tick_n(3);
        expect_out("rel3", 16'h0020, 0, 1, 0, 5'd1);
        sw[3] = 1'b1; cyc(2); tick_n(2);
        lift_open = 1'b1; tick_n(1); lift_open = 1'b0;
        expect_out("rise_open3", 16'h0020, 0, 1, 0, 5'd1);
        tick_n(2);
        expect_out("held3", 16'h0020, 0, 1, 0, 5'd1);

        // Clear floor 5, then end floors 0 and 15
        lift_num = 4'd5; lift_open = 1'b1; cyc(1); lift_open = 1'b0;
        expect_out("clr5", 16'h0000, 0, 0, 0, 5'd0);
        lift_num = 4'd0; sw = 16'h8001; cyc(2); tick_n(3);
        expect_out("ends_lo", 16'h8001, 1, 1, 0, 5'd2);
        lift_num = 4'd15; cyc(1);
        expect_out("ends_hi", 16'h8001, 1, 0, 1, 5'd2);

        // Set floor 4 and clear floor 15 on the same edge
        sw = 16'h8011; cyc(2); tick_n(2);
        tick = 1'b1; cyc(1); tick = 1'b0;
        lift_open = 1'b1; cyc(1); lift_open = 1'b0;
        expect_out("set4_clr15", 16'h0011, 0, 0, 1, 5'd2);

        // All floors, then asynchronous reset mid-cycle
        sw = 16'h0000; cyc(2); tick_n(3);
        lift_num = 4'd0; sw = 16'hFFFF; cyc(2); tick_n(3);
        expect_out("all", 16'hFFFF, 1, 1, 0, 5'd16);
        #1 rst_n = 1'b0;
        #1 expect_out("async_rst", 16'h0000, 0, 0, 0, 5'd0);
        #1 rst_n = 1'b1;
        cyc(2); tick_n(2);
        expect_out("rst_partial", 16'h0000, 0, 0, 0, 5'd0);
        tick_n(1);
        expect_out("rst_held", 16'hFFFF, 1, 1, 0, 5'd16);

        // Reset during debounce discards the partial run
        rst_n = 1'b0; sw = 16'h0000; cyc(1); rst_n = 1'b1; cyc(1);
        sw = 16'h0200; cyc(2); tick_n(2);
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        cyc(2); tick_n(1);
        expect_out("deb_discard", 16'h0000, 0, 0, 0, 5'd0);
        tick_n(2);
        expect_out("deb_restart", 16'h0200, 0, 1, 0, 5'd1);

        #1;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
